addstep_bank: RTL and testbench

//  Multi-channel chip bank for the Indian-poker datapath; supersedes the fixed add-ten block.

---
 rtl/addstep_bank.sv | 162 ++++++++++++++++
 tb/tb_addstep_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/addstep_bank.sv
// addstep_bank: multi-channel chip bank for the Indian-poker datapath.
// Each channel holds one player's WIDTH-bit chip count. IDLE accepts a
// level load (ld) or a rising edge on s, which adds or subtracts STEP on
// channel ch. A step finishes two edges after it is accepted.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   b             load value for channel ch
//   ld            load strobe (level), acted on in IDLE only; beats an s edge
//   s, sub        step request (rising edge) and direction (1 = subtract)
//   ch            channel select, sampled with ld or the s edge
//   o             count of live channel ch (0 when ch is out of range)
//   t             sum of all channel counts
//   done          one-cycle completion pulse; sat/err are valid with it
//   sat           result clamped (or carry/borrow in the wrap build)
//   err           ch >= CHANNELS, nothing written
//
// Build option: define ADDSTEP_WRAP_EN to make results wrap modulo 2**WIDTH.
// In that build, sat reports the carry or borrow instead of a clamp.

module addstep_lane #(
  parameter int WIDTH = 8,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= WIDTH'(INIT);
    else if (we) q <= d;
  end
endmodule

module addstep_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int STEP     = 10,
  parameter int INIT     = 0,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    b,
  input  logic                ld,
  input  logic                s,
  input  logic                sub,
  input  logic [CW-1:0]       ch,
  output logic [WIDTH-1:0]    o,
  output logic [WIDTH+CW-1:0] t,
  output logic                done,
  output logic                sat,
  output logic                err
);
  typedef enum logic [1:0] {IDLE, APPLY, ACK} state_t;

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [CW:0]    NCH    = (CW+1)'(CHANNELS);

  state_t                         state;
  logic                           s_d;
  logic [CW-1:0]                  ch_q;
  logic                           sub_q;
  logic [WIDTH-1:0]               res_q;
  logic                           sat_q, err_q;
  logic [CHANNELS-1:0][WIDTH-1:0] cnt;
  logic [CHANNELS-1:0]            we;
  logic [WIDTH-1:0]               wd;
  logic [WIDTH-1:0]               cur, nxt;
  logic [WIDTH:0]                 sum, dif;
  logic                           flow, s_edge, ch_bad, chq_bad;

  assign s_edge  = s & ~s_d;
  assign ch_bad  = {1'b0, ch}   >= NCH;
  assign chq_bad = {1'b0, ch_q} >= NCH;
  // Loads write straight from b; step results come from res_q in ACK.
  assign wd      = (state == ACK) ? res_q : b;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign we[g] = (state == IDLE && ld && ch == CW'(g)) ||
                   (state == ACK && !err_q && ch_q == CW'(g));
    addstep_lane #(.WIDTH(WIDTH), .INIT(INIT)) u_lane (
      .clk (clk),
      .rst (rst),
      .we  (we[g]),
      .d   (wd),
      .q   (cnt[g])
    );
  end

  // Read muxes: o follows the live ch, cur follows the latched ch_q.
  always_comb begin
    o   = '0;
    cur = '0;
    t   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == CW'(i))   o   = cnt[i];
      if (ch_q == CW'(i)) cur = cnt[i];
      t = t + (WIDTH+CW)'(cnt[i]);
    end
  end

  // One extra bit catches the add carry and the subtract borrow.
  always_comb begin
    sum  = {1'b0, cur} + STEP_W;
    dif  = {1'b0, cur} - STEP_W;
    flow = sub_q ? dif[WIDTH] : sum[WIDTH];
`ifdef ADDSTEP_WRAP_EN
    nxt  = sub_q ? dif[WIDTH-1:0] : sum[WIDTH-1:0];
`else
    if (sub_q) nxt = flow ? '0 : dif[WIDTH-1:0];
    else       nxt = flow ? '1 : sum[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s_d   <= 1'b1;  // a held s is not an edge after reset
      ch_q  <= '0;
      sub_q <= 1'b0;
      res_q <= '0;
      sat_q <= 1'b0;
      err_q <= 1'b0;
      done  <= 1'b0;
      sat   <= 1'b0;
      err   <= 1'b0;
    end else begin
      s_d  <= s;
      done <= 1'b0;
      sat  <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ld) begin
            done <= 1'b1;
            err  <= ch_bad;
          end else if (s_edge) begin
            ch_q  <= ch;
            sub_q <= sub;
            state <= APPLY;
          end
        end
        APPLY: begin
          res_q <= nxt;
          err_q <= chq_bad;
          sat_q <= flow & ~chq_bad;
          state <= ACK;
        end
        ACK: begin
          done  <= 1'b1;
          sat   <= sat_q;
          err   <= err_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addstep_bank.sv
module tb_addstep_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] b, o;
  logic       ld, s, sub, ch, done, sat, err;
  logic [8:0] t;
  logic [7:0] b3, o3;
  logic       ld3, s3, sub3, done3, sat3, err3;
  logic [1:0] ch3;
  logic [9:0] t3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addstep_bank #(.WIDTH(8), .CHANNELS(2), .STEP(10), .INIT(0)) u_dut (
    .clk(clk), .rst(rst), .b(b), .ld(ld), .s(s), .sub(sub), .ch(ch),
    .o(o), .t(t), .done(done), .sat(sat), .err(err));

  addstep_bank #(.WIDTH(8), .CHANNELS(3), .STEP(10), .INIT(0)) u_dut3 (
    .clk(clk), .rst(rst), .b(b3), .ld(ld3), .s(s3), .sub(sub3), .ch(ch3),
    .o(o3), .t(t3), .done(done3), .sat(sat3), .err(err3));

  typedef struct {
    bit         is_ld;
    bit         sub;
    logic       ch;
    logic [7:0] b;
    int         hold;
    logic [7:0] so;  int ssat; int st;   // saturating build
    logic [7:0] wo;  int wsat; int wt;   // wrapping build
  } vec_t;

  typedef struct {
    logic [7:0] o;
    logic       sat;
    logic       err;
    int         t;
  } exp_t;

  vec_t tbl[12];
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done o=%0d t=%0d", o, t);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_o",   o,   e.o);
        chk("done_sat", sat, e.sat);
        chk("done_err", err, e.err);
        chk("done_t",   t,   e.t);
      end
    end
  end

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout pending=%0d expected=0", nm, sbq.size());
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic exp_t pick(input vec_t v);
    exp_t e;
`ifdef ADDSTEP_WRAP_EN
    e = '{o: v.wo, sat: v.wsat[0], err: 1'b0, t: v.wt};
`else
    e = '{o: v.so, sat: v.ssat[0], err: 1'b0, t: v.st};
`endif
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n, extra;
    //           ld sub ch  b    hold  sat: o  s  t    wrap: o  s  t
    tbl[0]  = '{1, 0, 0, 8'd1,   1,  8'd1,   0, 1,   8'd1,   0, 1};
    tbl[1]  = '{0, 0, 0, 8'd0,  10,  8'd11,  0, 11,  8'd11,  0, 11};
    tbl[2]  = '{1, 0, 1, 8'd250, 1,  8'd250, 0, 261, 8'd250, 0, 261};
    tbl[3]  = '{0, 0, 1, 8'd0,   1,  8'd255, 1, 266, 8'd4,   1, 15};
    tbl[4]  = '{1, 0, 0, 8'd5,   1,  8'd5,   0, 260, 8'd5,   0, 9};
    tbl[5]  = '{0, 1, 0, 8'd0,   1,  8'd0,   1, 255, 8'd251, 1, 255};
    tbl[6]  = '{0, 1, 0, 8'd0,   1,  8'd0,   1, 255, 8'd241, 0, 245};
    tbl[7]  = '{0, 1, 1, 8'd0,   1,  8'd245, 0, 245, 8'd250, 1, 491};
    tbl[8]  = '{0, 0, 0, 8'd0,   1,  8'd10,  0, 255, 8'd251, 0, 501};
    tbl[9]  = '{1, 0, 1, 8'd255, 1,  8'd255, 0, 265, 8'd255, 0, 506};
    tbl[10] = '{0, 0, 1, 8'd0,   1,  8'd255, 1, 265, 8'd9,   1, 260};
    tbl[11] = '{0, 1, 0, 8'd0,   1,  8'd0,   0, 255, 8'd241, 0, 250};

    // Reset with s held high through release: no operation may start.
    rst = 1'b1; s = 1'b1; ld = 1'b0; sub = 1'b0; ch = 1'b0; b = '0;
    s3 = 1'b0; ld3 = 1'b0; sub3 = 1'b0; ch3 = '0; b3 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_o", o, 0);
    chk("rst_t", t, 0);
    chk("rst_t3", t3, 0);
    repeat (4) begin
      chk("rst_held_s_done", done, 0);
      @(negedge clk);
    end
    chk("rst_held_s_o", o, 0);
    @(posedge clk); #1 s = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      ch = tbl[i].ch; sub = tbl[i].sub; b = tbl[i].b;
      sbq.push_back(pick(tbl[i]));
      e = pick(tbl[i]);
      if (tbl[i].is_ld) begin
        ld = 1'b1;
        @(posedge clk); #1 ld = 1'b0;
      end else begin
        s = 1'b1;
        repeat (tbl[i].hold) @(posedge clk);
        #1 s = 1'b0;
      end
      wait_drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_o_hold", i), o, e.o);
      chk($sformatf("vec%0d_t_hold", i), t, e.t);
    end

    // ld and an s edge together in IDLE: load only, one done.
    ch = 1'b0; b = 8'd77; ld = 1'b1; s = 1'b1;
`ifdef ADDSTEP_WRAP_EN
    sbq.push_back('{o: 8'd77, sat: 1'b0, err: 1'b0, t: 86});
`else
    sbq.push_back('{o: 8'd77, sat: 1'b0, err: 1'b0, t: 332});
`endif
    @(posedge clk); #1 ld = 1'b0;
    repeat (3) @(posedge clk);
    #1 s = 1'b0;
    wait_drain("ld_beats_s");
    repeat (4) @(posedge clk);
    #1 chk("ld_beats_s_o", o, 77);

    // A second s edge while busy (ACK) is dropped.
    sub = 1'b0; s = 1'b1;
`ifdef ADDSTEP_WRAP_EN
    sbq.push_back('{o: 8'd87, sat: 1'b0, err: 1'b0, t: 96});
`else
    sbq.push_back('{o: 8'd87, sat: 1'b0, err: 1'b0, t: 342});
`endif
    @(posedge clk); #1 s = 1'b0;
    @(posedge clk); #1 s = 1'b1;
    @(posedge clk); #1 s = 1'b0;
    wait_drain("busy_edge");
    repeat (5) @(posedge clk);
    #1 chk("busy_edge_o", o, 87);

    // Reset during APPLY: no done, everything back to INIT.
    s = 1'b1;
    @(posedge clk); #1 rst = 1'b1; s = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_apply_done", done, 0);
    end
    chk("rst_apply_o", o, 0);
    chk("rst_apply_t", t, 0);

    // Three-channel bank: out-of-range channel reports err, writes nothing.
    @(posedge clk); #1 ch3 = 2'd0; b3 = 8'd7; ld3 = 1'b1;
    @(posedge clk); #1 ld3 = 1'b0;
    @(negedge clk);
    chk("c3_ld_done", done3, 1);
    chk("c3_ld_o", o3, 7);
    chk("c3_ld_err", err3, 0);
    @(posedge clk); #1 ch3 = 2'd3; sub3 = 1'b0; s3 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done3 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("c3_err_done", done3, 1);
    chk("c3_err_err", err3, 1);
    chk("c3_err_sat", sat3, 0);
    chk("c3_err_t", t3, 7);
    chk("c3_err_o", o3, 0);
    s3 = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done3) extra++;
    end
    chk("c3_err_single_done", extra, 0);
    ch3 = 2'd0;
    #1 chk("c3_ch0_kept", o3, 7);
    @(posedge clk); #1 ch3 = 2'd3; b3 = 8'd99; ld3 = 1'b1;
    @(posedge clk); #1 ld3 = 1'b0;
    @(negedge clk);
    chk("c3_ld_bad_done", done3, 1);
    chk("c3_ld_bad_err", err3, 1);
    chk("c3_ld_bad_t", t3, 7);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
